sal_bk_ctrl_pp: RTL and testbench

SAL_BK_CTRL_PP -- requirements
Module: sal_bk_ctrl_pp

---
 rtl/sal_pkg.sv | 29 ++
 rtl/sal_timing_cntr.sv | 26 ++
 rtl/sal_bk_ctrl_pp.sv | 207 ++++++++++++++++++++
 tb/tb_sal_bk_ctrl_pp.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sal_pkg.sv
// Shared types and defaults for the SAL bank controller slice.
package sal_pkg;

   typedef enum logic [1:0] {
      PM_OPEN    = 2'd0,
      PM_CLOSED  = 2'd1,
      PM_TIMEOUT = 2'd2,
      PM_RSVD    = 2'd3
   } page_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      ACTIVATING,
      ACTIVE,
      READING,
      WRITING,
      AUTOPRE,
      PRECHARGING,
      REFRESHING
   } bank_state_e;

   localparam int MAX_PP_DEF = 8;

   // The reserved encoding behaves exactly like OPEN.
   function automatic page_mode_e norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? PM_OPEN : page_mode_e'(m);
   endfunction

endpackage

// File: rtl/sal_timing_cntr.sv
// Down-counter guarding one inter-command constraint; is_zero means "met".
module sal_timing_cntr #(
   parameter int TW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          is_zero
);

   logic [TW-1:0] cnt;

   // Reload when the guarded command is granted, then count down and hold at zero.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign is_zero = (cnt == '0);

endmodule

// File: rtl/sal_bk_ctrl_pp.sv
// Single-bank DRAM command controller with page policy and postponed refresh.
module sal_bk_ctrl_pp
   import sal_pkg::*;
#(
   parameter int BK_ID  = 0,
   parameter int RA_W   = 16,
   parameter int CA_W   = 10,
   parameter int ID_W   = 8,
   parameter int TW     = 6,
   parameter int MAX_PP = MAX_PP_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      page_mode_i,
   input  logic [TW-1:0]   t_rcd_m2,
   input  logic [TW-1:0]   t_rp_m2,
   input  logic [TW-1:0]   t_rfc_m2,
   input  logic [TW-1:0]   burst_m2,
   input  logic [TW-1:0]   t_rc_m1,
   input  logic [TW-1:0]   t_ras_m1,
   input  logic [TW-1:0]   t_rtp_m1,
   input  logic [TW-1:0]   t_wtp_m1,
   input  logic [TW-1:0]   row_open_m1,
   input  logic            req_valid,
   input  logic            req_wr,
   input  logic [RA_W-1:0] req_ra,
   input  logic [CA_W-1:0] req_ca,
   input  logic [ID_W-1:0] req_id,
   input  logic [3:0]      req_len,
   output logic            req_ready,
   output logic            act_req,
   output logic            rd_req,
   output logic            wr_req,
   output logic            pre_req,
   output logic            ref_req,
   input  logic            act_gnt,
   input  logic            rd_gnt,
   input  logic            wr_gnt,
   input  logic            pre_gnt,
   input  logic            ref_gnt,
   output logic            sched_ap,
   output logic [2:0]      sched_ba,
   output logic [RA_W-1:0] sched_ra,
   output logic [CA_W-1:0] sched_ca,
   output logic [ID_W-1:0] sched_id,
   output logic [3:0]      sched_len,
   input  logic            ref_tick_i,
   output logic [3:0]      ref_pend_o,
   output logic            ref_urgent_o,
   output logic            ref_ovf_o
);

   localparam logic [3:0] PP_MAX = 4'(MAX_PP);

   bank_state_e     state;
   logic [TW:0]     cnt;
   logic [RA_W-1:0] open_row;
   page_mode_e      mode_q;
   logic            ap_q;
   logic            armed;
   logic [3:0]      pend;
   logic            ovf;

   logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire;
   logic trc_ok, tras_ok, trtp_ok, twtp_ok, ro_zero;
   logic pre_ok, hit, urgent, ref_want, close_want, phase_done;

   // The grant cycle itself is not part of the phase, so a phase of value+2
   // cycles needs value+1 in the counter on entry.
   function automatic logic [TW:0] phase_load(input logic [TW-1:0] v);
      return {1'b0, v} + 1'b1;
   endfunction

   assign act_fire = act_req & act_gnt;
   assign rd_fire  = rd_req  & rd_gnt;
   assign wr_fire  = wr_req  & wr_gnt;
   assign pre_fire = pre_req & pre_gnt;
   assign ref_fire = ref_req & ref_gnt;

   sal_timing_cntr #(.TW(TW)) u_trc  (.clk(clk), .rst(rst), .load(act_fire),
                                      .load_val(t_rc_m1),     .is_zero(trc_ok));
   sal_timing_cntr #(.TW(TW)) u_tras (.clk(clk), .rst(rst), .load(act_fire),
                                      .load_val(t_ras_m1),    .is_zero(tras_ok));
   sal_timing_cntr #(.TW(TW)) u_trtp (.clk(clk), .rst(rst), .load(rd_fire),
                                      .load_val(t_rtp_m1),    .is_zero(trtp_ok));
   sal_timing_cntr #(.TW(TW)) u_twtp (.clk(clk), .rst(rst), .load(wr_fire),
                                      .load_val(t_wtp_m1),    .is_zero(twtp_ok));
   sal_timing_cntr #(.TW(TW)) u_ropn (.clk(clk), .rst(rst), .load(rd_fire | wr_fire),
                                      .load_val(row_open_m1), .is_zero(ro_zero));

   assign pre_ok     = tras_ok & trtp_ok & twtp_ok;
   assign hit        = req_valid && (req_ra == open_row);
   assign urgent     = (pend == PP_MAX);
   assign ref_want   = urgent || ((pend != 4'd0) && !req_valid);
   assign close_want = (req_valid && !hit) || urgent ||
                       ((mode_q == PM_TIMEOUT) && ro_zero && !req_valid);
   assign phase_done = (cnt == '0);

   // Command requests and schedule fields; silenced for one cycle after reset.
   always_comb begin
      act_req   = 1'b0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      pre_req   = 1'b0;
      ref_req   = 1'b0;
      if (armed) begin
         case (state)
            IDLE: begin
               if (ref_want)
                  ref_req = trc_ok;
               else if (req_valid)
                  act_req = trc_ok;
            end
            ACTIVE: begin
               if (hit && !urgent) begin
                  rd_req = !req_wr;
                  wr_req = req_wr;
               end else if (close_want) begin
                  pre_req = pre_ok;
               end
            end
            default: ;
         endcase
      end
      sched_ra  = act_req ? req_ra : '0;
      sched_ca  = (rd_req | wr_req) ? req_ca  : '0;
      sched_id  = (rd_req | wr_req) ? req_id  : '0;
      sched_len = (rd_req | wr_req) ? req_len : '0;
      sched_ap  = (rd_req | wr_req) && (mode_q == PM_CLOSED);
   end

   assign req_ready    = rd_fire | wr_fire;
   assign sched_ba     = 3'(BK_ID);
   assign ref_pend_o   = pend;
   assign ref_urgent_o = urgent;
   assign ref_ovf_o    = ovf;

   // Bank state machine with its phase counter and per-row latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         open_row <= '0;
         mode_q   <= PM_OPEN;
         ap_q     <= 1'b0;
         armed    <= 1'b0;
      end else begin
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (ref_fire) begin
                  state <= REFRESHING;
                  cnt   <= phase_load(t_rfc_m2);
               end else if (act_fire) begin
                  state    <= ACTIVATING;
                  cnt      <= phase_load(t_rcd_m2);
                  open_row <= req_ra;
                  mode_q   <= norm_mode(page_mode_i);
               end
            end
            ACTIVATING: begin
               if (phase_done) state <= ACTIVE;
               else            cnt   <= cnt - 1'b1;
            end
            ACTIVE: begin
               if (rd_fire || wr_fire) begin
                  state <= rd_fire ? READING : WRITING;
                  cnt   <= phase_load(burst_m2);
                  ap_q  <= sched_ap;
               end else if (pre_fire) begin
                  state <= PRECHARGING;
                  cnt   <= phase_load(t_rp_m2);
               end
            end
            READING, WRITING: begin
               if (phase_done) state <= ap_q ? AUTOPRE : ACTIVE;
               else            cnt   <= cnt - 1'b1;
            end
            AUTOPRE: begin
               if (pre_ok) begin
                  state <= PRECHARGING;
                  cnt   <= phase_load(t_rp_m2);
               end
            end
            PRECHARGING, REFRESHING: begin
               if (phase_done) state <= IDLE;
               else            cnt   <= cnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Owed-refresh counter: saturates at MAX_PP and flags any tick lost there.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= 4'd0;
         ovf  <= 1'b0;
      end else if (ref_tick_i && !ref_fire) begin
         if (pend == PP_MAX) ovf  <= 1'b1;
         else                pend <= pend + 4'd1;
      end else if (ref_fire && !ref_tick_i) begin
         pend <= pend - 4'd1;
      end
   end

endmodule

// File: tb/tb_sal_bk_ctrl_pp.sv
// Directed scoreboard bench for the SAL bank controller.
module tb_sal_bk_ctrl_pp;
   import sal_pkg::*;

   localparam int RA_W = 16;
   localparam int CA_W = 10;
   localparam int ID_W = 8;
   localparam int TW   = 6;
   localparam int K_ACT = 0, K_RD = 1, K_WR = 2, K_PRE = 3, K_REF = 4, K_NONE = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [1:0] page_mode_i = 2'd0;
   logic [TW-1:0] t_rcd_m2 = 6'd2, t_rp_m2 = 6'd1, t_rfc_m2 = 6'd3, burst_m2 = 6'd2;
   logic [TW-1:0] t_rc_m1 = 6'd0, t_ras_m1 = 6'd0, t_rtp_m1 = 6'd0, t_wtp_m1 = 6'd0;
   logic [TW-1:0] row_open_m1 = 6'd4;
   logic req_valid = 1'b0, req_wr = 1'b0;
   logic [RA_W-1:0] req_ra = '0;
   logic [CA_W-1:0] req_ca = '0;
   logic [ID_W-1:0] req_id = '0;
   logic [3:0] req_len = '0;
   logic req_ready;
   logic act_req, rd_req, wr_req, pre_req, ref_req;
   logic act_gnt = 1'b0, rd_gnt = 1'b0, wr_gnt = 1'b0, pre_gnt = 1'b0, ref_gnt = 1'b0;
   logic sched_ap;
   logic [2:0] sched_ba;
   logic [RA_W-1:0] sched_ra;
   logic [CA_W-1:0] sched_ca;
   logic [ID_W-1:0] sched_id;
   logic [3:0] sched_len;
   logic ref_tick_i = 1'b0;
   logic [3:0] ref_pend_o;
   logic ref_urgent_o, ref_ovf_o;

   always #5 clk = ~clk;

   sal_bk_ctrl_pp #(.BK_ID(5), .RA_W(RA_W), .CA_W(CA_W), .ID_W(ID_W), .TW(TW), .MAX_PP(8)) dut (
      .clk(clk), .rst(rst), .page_mode_i(page_mode_i),
      .t_rcd_m2(t_rcd_m2), .t_rp_m2(t_rp_m2), .t_rfc_m2(t_rfc_m2), .burst_m2(burst_m2),
      .t_rc_m1(t_rc_m1), .t_ras_m1(t_ras_m1), .t_rtp_m1(t_rtp_m1), .t_wtp_m1(t_wtp_m1),
      .row_open_m1(row_open_m1),
      .req_valid(req_valid), .req_wr(req_wr), .req_ra(req_ra), .req_ca(req_ca),
      .req_id(req_id), .req_len(req_len), .req_ready(req_ready),
      .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req), .pre_req(pre_req), .ref_req(ref_req),
      .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt), .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
      .sched_ap(sched_ap), .sched_ba(sched_ba), .sched_ra(sched_ra), .sched_ca(sched_ca),
      .sched_id(sched_id), .sched_len(sched_len),
      .ref_tick_i(ref_tick_i), .ref_pend_o(ref_pend_o), .ref_urgent_o(ref_urgent_o),
      .ref_ovf_o(ref_ovf_o)
   );

   typedef struct {
      int              kind;
      logic [RA_W-1:0] ra;
      logic [CA_W-1:0] ca;
      logic [ID_W-1:0] id;
      logic [3:0]      len;
      logic            ap;
      int              gap;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_fire = 0;
   bit   acc = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int kind, input logic [RA_W-1:0] ra, input logic [CA_W-1:0] ca,
                       input logic [ID_W-1:0] id, input logic [3:0] len, input logic ap,
                       input int gap);
      exp_t e;
      e.kind = kind; e.ra = ra; e.ca = ca; e.id = id; e.len = len; e.ap = ap; e.gap = gap;
      sb.push_back(e);
   endtask

   task automatic drive_req(input logic v, input logic wr, input logic [RA_W-1:0] ra,
                            input logic [CA_W-1:0] ca, input logic [ID_W-1:0] id,
                            input logic [3:0] len);
      req_valid = v; req_wr = wr; req_ra = ra; req_ca = ca; req_id = id; req_len = len;
   endtask

   // One clock cycle: grant whatever is requested, score any issued command.
   task automatic tick();
      int   k;
      exp_t e;
      #1;
      act_gnt = act_req; rd_gnt = rd_req; wr_gnt = wr_req; pre_gnt = pre_req; ref_gnt = ref_req;
      #1;
      if (act_req | rd_req | wr_req | pre_req | ref_req)
         chk("one_req", $countones({act_req, rd_req, wr_req, pre_req, ref_req}), 1);
      k = K_NONE;
      if (act_req)      k = K_ACT;
      else if (rd_req)  k = K_RD;
      else if (wr_req)  k = K_WR;
      else if (pre_req) k = K_PRE;
      else if (ref_req) k = K_REF;
      if (k != K_NONE) begin
         if (sb.size() == 0) begin
            chk("unexpected_cmd", k, K_NONE);
         end else begin
            e = sb.pop_front();
            chk("cmd_kind", k, e.kind);
            if (e.gap >= 0) chk("cmd_gap", cyc - last_fire, e.gap);
            chk("sched_ba", sched_ba, 5);
            chk("req_ready", req_ready, (k == K_RD || k == K_WR) ? 1 : 0);
            if (k == K_ACT) begin
               chk("act_ra", sched_ra, e.ra);
               chk("act_ca0", sched_ca, 0);
               chk("act_id0", sched_id, 0);
               chk("act_ap0", sched_ap, 0);
            end else if (k == K_RD || k == K_WR) begin
               chk("col_ra0", sched_ra, 0);
               chk("col_ca", sched_ca, e.ca);
               chk("col_id", sched_id, e.id);
               chk("col_len", sched_len, e.len);
               chk("col_ap", sched_ap, e.ap);
            end else begin
               chk("pr_ra0", sched_ra, 0);
               chk("pr_ca0", sched_ca, 0);
               chk("pr_len0", sched_len, 0);
            end
         end
         last_fire = cyc;
      end else if (req_ready) begin
         chk("stray_ready", req_ready, 0);
      end
      if (req_ready) acc = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
      act_gnt = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; pre_gnt = 1'b0; ref_gnt = 1'b0;
   endtask

   task automatic run_until_accept(input int max);
      acc = 1'b0;
      for (int i = 0; i < max && !acc; i++) tick();
      chk("accept", acc, 1);
   endtask

   task automatic drain(input int max);
      for (int i = 0; i < max && sb.size() > 0; i++) tick();
      chk("drain", sb.size(), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      @(posedge clk);
      #1;
      idle(2);
      chk("rst_act", act_req, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_pend", ref_pend_o, 0);
      chk("rst_urg", ref_urgent_o, 0);
      chk("rst_ovf", ref_ovf_o, 0);
      chk("rst_ba", sched_ba, 5);
      chk("rst_ra0", sched_ra, 0);

      // Open page read, row stays open, then hits without a new ACT.
      rst = 1'b0;
      page_mode_i = PM_OPEN;
      drive_req(1, 0, 16'd5, 10'h12, 8'h33, 4'd4);
      push(K_ACT, 16'd5, 0, 0, 0, 0, -1);
      push(K_RD, 0, 10'h12, 8'h33, 4'd4, 0, 5);
      run_until_accept(30);
      req_valid = 1'b0;
      idle(8);
      drive_req(1, 1, 16'd5, 10'h40, 8'h34, 4'd2);
      push(K_WR, 0, 10'h40, 8'h34, 4'd2, 0, -1);
      run_until_accept(10);
      page_mode_i = PM_CLOSED;
      drive_req(1, 0, 16'd5, 10'h01, 8'h35, 4'd1);
      push(K_RD, 0, 10'h01, 8'h35, 4'd1, 0, -1);
      run_until_accept(10);
      req_valid = 1'b0;
      idle(6);

      // Closed page write with auto-precharge held off by tWTP.
      t_wtp_m1 = 6'd6;
      drive_req(1, 1, 16'd3, 10'h07, 8'h40, 4'd8);
      push(K_PRE, 0, 0, 0, 0, 0, -1);
      push(K_ACT, 16'd3, 0, 0, 0, 0, 4);
      push(K_WR, 0, 10'h07, 8'h40, 4'd8, 1, 5);
      run_until_accept(40);
      drive_req(1, 0, 16'd3, 10'h08, 8'h41, 4'd1);
      push(K_ACT, 16'd3, 0, 0, 0, 0, 11);
      push(K_RD, 0, 10'h08, 8'h41, 4'd1, 1, 5);
      run_until_accept(40);
      req_valid = 1'b0;
      page_mode_i = PM_OPEN;
      t_wtp_m1 = 6'd0;
      idle(12);

      // Row miss with precharge held off by tRAS.
      t_ras_m1 = 6'd10;
      drive_req(1, 0, 16'd7, 10'h02, 8'h50, 4'd4);
      push(K_ACT, 16'd7, 0, 0, 0, 0, -1);
      push(K_RD, 0, 10'h02, 8'h50, 4'd4, 0, 5);
      run_until_accept(30);
      drive_req(1, 0, 16'd9, 10'h03, 8'h51, 4'd4);
      push(K_PRE, 0, 0, 0, 0, 0, 6);
      push(K_ACT, 16'd9, 0, 0, 0, 0, 4);
      push(K_RD, 0, 10'h03, 8'h51, 4'd4, 0, 5);
      run_until_accept(40);
      req_valid = 1'b0;
      t_ras_m1 = 6'd0;
      idle(8);

      // Refresh backlog reaching MAX_PP under a stream of hits.
      drive_req(1, 0, 16'd9, 10'h04, 8'h60, 4'd4);
      push(K_RD, 0, 10'h04, 8'h60, 4'd4, 0, -1);
      push(K_RD, 0, 10'h04, 8'h60, 4'd4, 0, 5);
      push(K_PRE, 0, 0, 0, 0, 0, 5);
      push(K_REF, 0, 0, 0, 0, 0, 4);
      ref_tick_i = 1'b1;
      idle(8);
      ref_tick_i = 1'b0;
      chk("pend_full", ref_pend_o, 8);
      chk("urgent", ref_urgent_o, 1);
      chk("no_ovf_yet", ref_ovf_o, 0);
      idle(4);
      ref_tick_i = 1'b1;
      tick();
      ref_tick_i = 1'b0;
      chk("ovf_set", ref_ovf_o, 1);
      chk("pend_sat", ref_pend_o, 8);
      drain(10);
      chk("pend_after_ref", ref_pend_o, 7);
      chk("urgent_clr", ref_urgent_o, 0);
      req_valid = 1'b0;
      for (int i = 0; i < 7; i++) push(K_REF, 0, 0, 0, 0, 0, 6);
      drain(80);
      chk("pend_empty", ref_pend_o, 0);

      // Timeout page policy closes an idle row once row-open expires.
      page_mode_i = PM_TIMEOUT;
      t_rtp_m1 = 6'd2;
      drive_req(1, 0, 16'd2, 10'h05, 8'h70, 4'd3);
      push(K_ACT, 16'd2, 0, 0, 0, 0, -1);
      push(K_RD, 0, 10'h05, 8'h70, 4'd3, 0, 5);
      push(K_PRE, 0, 0, 0, 0, 0, 5);
      run_until_accept(30);
      req_valid = 1'b0;
      drain(20);
      chk("ovf_sticky", ref_ovf_o, 1);

      // Reset in the middle of a refresh.
      push(K_REF, 0, 0, 0, 0, 0, -1);
      ref_tick_i = 1'b1;
      tick();
      ref_tick_i = 1'b0;
      drain(20);
      tick();
      rst = 1'b1;
      drive_req(1, 0, 16'd4, 10'h09, 8'h77, 4'd2);
      tick();
      rst = 1'b0;
      chk("post_rst_act", act_req, 0);
      chk("post_rst_rd", rd_req, 0);
      chk("post_rst_pre", pre_req, 0);
      chk("post_rst_ref", ref_req, 0);
      chk("post_rst_ready", req_ready, 0);
      chk("post_rst_pend", ref_pend_o, 0);
      chk("post_rst_ovf", ref_ovf_o, 0);
      chk("post_rst_ra0", sched_ra, 0);
      tick();
      push(K_ACT, 16'd4, 0, 0, 0, 0, -1);
      drain(1);
      push(K_RD, 0, 10'h09, 8'h77, 4'd2, 0, 5);
      push(K_PRE, 0, 0, 0, 0, 0, 5);
      run_until_accept(20);
      req_valid = 1'b0;
      drain(20);
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
